// File: rtl/ram_uart_sequencer_pkg.sv
// Shared types and widths for the RAM/UART sequencer: FSM state encoding and bus widths.
package ram_uart_sequencer_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [3:0] {
        ST_RX_LO  = 4'd0,
        ST_RX_HI  = 4'd1,
        ST_WR_REQ = 4'd2,
        ST_WR_REL = 4'd3,
        ST_RD_REQ = 4'd4,
        ST_RD_REL = 4'd5,
        ST_TX_LO  = 4'd6,
        ST_TX_LOW = 4'd7,
        ST_TX_HI  = 4'd8,
        ST_TX_HIW = 4'd9,
        ST_ERR    = 4'd10
    } state_t;

    // States in which we are waiting on the controller's done handshake.
    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_WR_REQ) || (s == ST_WR_REL) || (s == ST_RD_REQ) || (s == ST_RD_REL);
    endfunction

endpackage

// File: rtl/ram_uart_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (the controller's done flag).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ram_uart_sequencer.sv
// Collects UART byte pairs into 16-bit words, writes them to SRAM through the controller,
// then reads them back and streams the bytes out over UART TX (little-endian both ways).
//
// state  | meaning
// RX_LO  | waiting for low byte of next word
// RX_HI  | waiting for high byte; on arrival latch word and address
// WR_REQ | write strobe held until done_s
// WR_REL | write strobe released, waiting for done_s to fall
// RD_REQ | read strobe held until done_s, then capture read data
// RD_REL | read strobe released, waiting for done_s to fall
// TX_LO  | send low byte once TX idle
// TX_LOW | guard cycle while TX busy catches up
// TX_HI  | send high byte once TX idle
// TX_HIW | advance word index, read next word or finish
// ERR    | done handshake timed out; parked until reset
module ram_uart_sequencer
    import ram_uart_sequencer_pkg::*;
#(
    parameter int                WORD_COUNT   = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                DONE_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              overrun,
    output logic              error
);

    localparam int              TMO_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [ADDR_W:0] WC_L  = (ADDR_W + 1)'(WORD_COUNT);

    state_t              state;
    state_t              state_nxt;
    logic                done_s;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W:0]     idx_inc;
    logic                last_word;
    logic [7:0]          lo;
    logic [DATA_W-1:0]   rdata;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                tmo_hit;

    sync_2ff u_done_sync (
        .clk (clk),
        .rst (rst),
        .d   (mem_done),
        .q   (done_s)
    );

    // One extra bit so WORD_COUNT == 2^18 is representable.
    assign idx_inc   = {1'b0, idx} + (ADDR_W + 1)'(1);
    assign last_word = (idx_inc == WC_L);
    assign tmo_hit   = (tmo_cnt == TMO_W'(DONE_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RX_LO;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RX_LO:  if (rx_valid) state_nxt = ST_RX_HI;
            ST_RX_HI:  if (rx_valid) state_nxt = ST_WR_REQ;
            ST_WR_REQ: begin
                if (done_s)       state_nxt = ST_WR_REL;
                else if (tmo_hit) state_nxt = ST_ERR;
            end
            ST_WR_REL: begin
                if (!done_s)      state_nxt = last_word ? ST_RD_REQ : ST_RX_LO;
                else if (tmo_hit) state_nxt = ST_ERR;
            end
            ST_RD_REQ: begin
                if (done_s)       state_nxt = ST_RD_REL;
                else if (tmo_hit) state_nxt = ST_ERR;
            end
            ST_RD_REL: begin
                if (!done_s)      state_nxt = ST_TX_LO;
                else if (tmo_hit) state_nxt = ST_ERR;
            end
            ST_TX_LO:  if (!tx_busy) state_nxt = ST_TX_LOW;
            ST_TX_LOW: state_nxt = ST_TX_HI;
            ST_TX_HI:  if (!tx_busy) state_nxt = ST_TX_HIW;
            ST_TX_HIW: state_nxt = last_word ? ST_RX_LO : ST_RD_REQ;
            ST_ERR:    state_nxt = ST_ERR;
            default:   state_nxt = ST_ERR;
        endcase
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        tx_start = 1'b0;
        error    = 1'b0;
        case (state)
            ST_WR_REQ: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            ST_RD_REQ: begin
                mem_en = 1'b1;
                mem_re = 1'b1;
            end
            ST_WR_REL, ST_RD_REL, ST_TX_LO, ST_TX_HI: mem_en = 1'b1;
            ST_TX_LOW, ST_TX_HIW: begin
                mem_en   = 1'b1;
                tx_start = 1'b1;
            end
            ST_ERR:  error = 1'b1;
            default: ;
        endcase
        busy = (state != ST_RX_LO) || (idx != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            lo        <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tx_data   <= '0;
            overrun   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (state_nxt != state) begin
                tmo_cnt <= '0;
            end else if (is_mem_wait(state)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (rx_valid && (state != ST_RX_LO) && (state != ST_RX_HI)) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_RX_LO: if (rx_valid) lo <= rx_data;
                ST_RX_HI: begin
                    if (rx_valid) begin
                        mem_wdata <= {rx_data, lo};
                        mem_addr  <= BASE_ADDR + idx;
                    end
                end
                ST_WR_REL: begin
                    if (!done_s) begin
                        if (last_word) begin
                            idx      <= '0;
                            mem_addr <= BASE_ADDR;
                        end else begin
                            idx <= idx_inc[ADDR_W-1:0];
                        end
                    end
                end
                ST_RD_REQ: if (done_s) rdata <= mem_rdata;
                ST_TX_LO:  if (!tx_busy) tx_data <= rdata[7:0];
                ST_TX_HI:  if (!tx_busy) tx_data <= rdata[15:8];
                ST_TX_HIW: begin
                    if (last_word) begin
                        idx <= '0;
                    end else begin
                        idx      <= idx_inc[ADDR_W-1:0];
                        mem_addr <= BASE_ADDR + idx_inc[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_uart_sequencer.sv
// Bench for ram_uart_sequencer: SRAM-controller and UART-TX models, scoreboarded writes and TX bytes.
module tb_ram_uart_sequencer;

    localparam int WC  = 2;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        mem_en, mem_we, mem_re;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_done  = 1'b0;
    logic        busy, overrun, error;

    always #5 clk = ~clk;

    ram_uart_sequencer #(
        .WORD_COUNT   (WC),
        .BASE_ADDR    (18'd0),
        .DONE_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy),
        .overrun   (overrun),
        .error     (error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard: expected pushed at stimulus, actual logged by the models
    logic [33:0] wr_exp[$];
    logic [33:0] wr_log[$];
    logic [7:0]  tx_exp[$];
    logic [7:0]  tx_log[$];

    // controller model
    bit          model_en   = 1'b1;
    int          done_delay = 1;
    int          dcnt       = 0;
    logic [15:0] mem [0:255];

    always @(posedge clk) begin
        if (mem_we || mem_re) begin
            if (!mem_done && model_en) begin
                if (dcnt >= done_delay - 1) begin
                    mem_done <= 1'b1;
                    dcnt     <= 0;
                    if (mem_we) begin
                        mem[mem_addr[7:0]] <= mem_wdata;
                        wr_log.push_back({mem_addr, mem_wdata});
                    end
                    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
                end else begin
                    dcnt <= dcnt + 1;
                end
            end
        end else begin
            mem_done <= 1'b0;
            dcnt     <= 0;
        end
    end

    // UART TX model: busy from the cycle after tx_start for four cycles
    logic uart_busy = 1'b0;
    int   ub_cnt    = 0;
    bit   busy_hold = 1'b0;
    assign tx_busy = uart_busy | busy_hold;

    always @(posedge clk) begin
        if (tx_start) begin
            uart_busy <= 1'b1;
            ub_cnt    <= 3;
        end else if (ub_cnt > 0) begin
            ub_cnt <= ub_cnt - 1;
        end else begin
            uart_busy <= 1'b0;
        end
    end

    // protocol monitors
    int          proto_viol = 0;
    int          addr_viol  = 0;
    int          txb_viol   = 0;
    int          tx_pulses  = 0;
    int          we_run     = 0;
    int          last_we_len = 0;
    logic        prev_we = 1'b0, prev_re = 1'b0;
    logic [17:0] held_addr = '0;
    logic [15:0] held_wdata = '0;

    always @(negedge clk) begin
        if ((mem_we && mem_re) || (prev_we && mem_re) || (prev_re && mem_we))
            proto_viol <= proto_viol + 1;
        if ((mem_we || mem_re) && (prev_we || prev_re) &&
            ((mem_addr !== held_addr) || (mem_wdata !== held_wdata)))
            addr_viol <= addr_viol + 1;
        if (mem_we) begin
            we_run <= we_run + 1;
        end else if (prev_we) begin
            last_we_len <= we_run;
            we_run      <= 0;
        end
        if (tx_start) begin
            tx_log.push_back(tx_data);
            tx_pulses <= tx_pulses + 1;
            if (tx_busy) txb_viol <= txb_viol + 1;
        end
        held_addr  <= mem_addr;
        held_wdata <= mem_wdata;
        prev_we    <= mem_we;
        prev_re    <= mem_re;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return mem_en;
            1:       return mem_we;
            2:       return mem_re;
            3:       return busy;
            4:       return tx_start;
            default: return error;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (sig(sel) === val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load_words(input logic [15:0] w0, input logic [15:0] w1, output bit ok);
        bit o;
        logic [15:0] w;
        ok = 1'b1;
        for (int i = 0; i < WC; i++) begin
            w = (i == 0) ? w0 : w1;
            wr_exp.push_back({18'(i), w});
            tx_exp.push_back(w[7:0]);
            tx_exp.push_back(w[15:8]);
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            if (i < WC - 1) begin
                wait_sig(0, 1'b1, 50, o);
                ok &= o;
                wait_sig(0, 1'b0, 300, o);
                ok &= o;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_re, tx_start, busy, overrun, error} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0000000",
                     {mem_en, mem_we, mem_re, tx_start, busy, overrun, error});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, tx_data} !== 42'h0)
            $display("FAIL reset_regs: got %h want 0", {mem_addr, mem_wdata, tx_data});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok1, ok2;
        logic [33:0] e, a;
        logic [7:0]  eb, ab;
        done_delay = 1;
        load_words(16'h1234, 16'h5678, ok1);
        wait_sig(3, 1'b0, 3000, ok2);
        n_checks++;
        if (!(ok1 && ok2)) $display("FAIL basic_complete: got load=%0d idle=%0d want 1 1", ok1, ok2);
        else n_pass++;
        n_checks++;
        if (wr_log.size() != wr_exp.size())
            $display("FAIL basic_wr_count: got %0d want %0d", wr_log.size(), wr_exp.size());
        else n_pass++;
        while (wr_exp.size() > 0 && wr_log.size() > 0) begin
            e = wr_exp.pop_front();
            a = wr_log.pop_front();
            n_checks++;
            if (a !== e) $display("FAIL basic_write: got %h want %h", a, e);
            else n_pass++;
        end
        n_checks++;
        if (tx_log.size() != tx_exp.size())
            $display("FAIL basic_tx_count: got %0d want %0d", tx_log.size(), tx_exp.size());
        else n_pass++;
        while (tx_exp.size() > 0 && tx_log.size() > 0) begin
            eb = tx_exp.pop_front();
            ab = tx_log.pop_front();
            n_checks++;
            if (ab !== eb) $display("FAIL basic_tx_byte: got %h want %h", ab, eb);
            else n_pass++;
        end
        wr_exp.delete(); wr_log.delete(); tx_exp.delete(); tx_log.delete();
        n_checks++;
        if ({mem_en, overrun, error} !== 3'b0)
            $display("FAIL basic_idle_flags: got %b want 000", {mem_en, overrun, error});
        else n_pass++;
    endtask

    task automatic test_done_delay;
        bit ok1, ok2;
        int pv0, av0;
        logic [33:0] e, a;
        logic [7:0]  eb, ab;
        pv0 = proto_viol;
        av0 = addr_viol;
        done_delay = 5;
        load_words(16'hBEEF, 16'h0001, ok1);
        wait_sig(3, 1'b0, 3000, ok2);
        n_checks++;
        if (!(ok1 && ok2)) $display("FAIL delay_complete: got load=%0d idle=%0d want 1 1", ok1, ok2);
        else n_pass++;
        n_checks++;
        if (last_we_len < 7 || last_we_len > 8)
            $display("FAIL delay_we_hold: got %0d cycles want 7..8", last_we_len);
        else n_pass++;
        n_checks++;
        if (proto_viol != pv0)
            $display("FAIL delay_we_re_overlap: got %0d violations want 0", proto_viol - pv0);
        else n_pass++;
        n_checks++;
        if (addr_viol != av0)
            $display("FAIL delay_addr_stable: got %0d violations want 0", addr_viol - av0);
        else n_pass++;
        n_checks++;
        if (wr_log.size() != wr_exp.size() || tx_log.size() != tx_exp.size())
            $display("FAIL delay_counts: got wr=%0d tx=%0d want wr=%0d tx=%0d",
                     wr_log.size(), tx_log.size(), wr_exp.size(), tx_exp.size());
        else n_pass++;
        while (wr_exp.size() > 0 && wr_log.size() > 0) begin
            e = wr_exp.pop_front();
            a = wr_log.pop_front();
            n_checks++;
            if (a !== e) $display("FAIL delay_write: got %h want %h", a, e);
            else n_pass++;
        end
        while (tx_exp.size() > 0 && tx_log.size() > 0) begin
            eb = tx_exp.pop_front();
            ab = tx_log.pop_front();
            n_checks++;
            if (ab !== eb) $display("FAIL delay_tx_byte: got %h want %h", ab, eb);
            else n_pass++;
        end
        wr_exp.delete(); wr_log.delete(); tx_exp.delete(); tx_log.delete();
    endtask

    task automatic test_overrun;
        bit ok1, ok2, ok3;
        logic [33:0] e, a;
        logic [7:0]  eb, ab;
        done_delay = 2;
        load_words(16'hC3A5, 16'h0F1E, ok1);
        wait_sig(4, 1'b1, 500, ok2);
        send_byte(8'hAA);
        wait_sig(3, 1'b0, 3000, ok3);
        n_checks++;
        if (!(ok1 && ok2 && ok3)) $display("FAIL ovr_complete: got %0d%0d%0d want 111", ok1, ok2, ok3);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun);
        else n_pass++;
        n_checks++;
        if (wr_log.size() != wr_exp.size() || tx_log.size() != tx_exp.size())
            $display("FAIL ovr_counts: got wr=%0d tx=%0d want wr=%0d tx=%0d",
                     wr_log.size(), tx_log.size(), wr_exp.size(), tx_exp.size());
        else n_pass++;
        while (wr_exp.size() > 0 && wr_log.size() > 0) begin
            e = wr_exp.pop_front();
            a = wr_log.pop_front();
            n_checks++;
            if (a !== e) $display("FAIL ovr_write: got %h want %h", a, e);
            else n_pass++;
        end
        while (tx_exp.size() > 0 && tx_log.size() > 0) begin
            eb = tx_exp.pop_front();
            ab = tx_log.pop_front();
            n_checks++;
            if (ab !== eb) $display("FAIL ovr_tx_byte: got %h want %h", ab, eb);
            else n_pass++;
        end
        wr_exp.delete(); wr_log.delete(); tx_exp.delete(); tx_log.delete();
    endtask

    task automatic test_reset_mid_write;
        bit ok1, ok2, ok3;
        logic [33:0] e, a;
        logic [7:0]  eb, ab;
        done_delay = 10;
        send_byte(8'h11);
        send_byte(8'h22);
        wait_sig(1, 1'b1, 20, ok1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (!ok1 || {mem_en, mem_we, mem_re} !== 3'b000)
            $display("FAIL rst_strobe_drop: got seen=%0d en/we/re=%b want 1 000", ok1, {mem_en, mem_we, mem_re});
        else n_pass++;
        n_checks++;
        if ({busy, overrun, error} !== 3'b000)
            $display("FAIL rst_flags: got %b want 000", {busy, overrun, error});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_log.size() != 0) $display("FAIL rst_no_write: got %0d writes want 0", wr_log.size());
        else n_pass++;
        rst = 1'b0;
        done_delay = 3;
        load_words(16'h2211, 16'h4433, ok2);
        wait_sig(3, 1'b0, 3000, ok3);
        n_checks++;
        if (!(ok2 && ok3)) $display("FAIL rst_restart: got load=%0d idle=%0d want 1 1", ok2, ok3);
        else n_pass++;
        n_checks++;
        if (wr_log.size() != wr_exp.size() || tx_log.size() != tx_exp.size())
            $display("FAIL rst_counts: got wr=%0d tx=%0d want wr=%0d tx=%0d",
                     wr_log.size(), tx_log.size(), wr_exp.size(), tx_exp.size());
        else n_pass++;
        while (wr_exp.size() > 0 && wr_log.size() > 0) begin
            e = wr_exp.pop_front();
            a = wr_log.pop_front();
            n_checks++;
            if (a !== e) $display("FAIL rst_write: got %h want %h", a, e);
            else n_pass++;
        end
        while (tx_exp.size() > 0 && tx_log.size() > 0) begin
            eb = tx_exp.pop_front();
            ab = tx_log.pop_front();
            n_checks++;
            if (ab !== eb) $display("FAIL rst_tx_byte: got %h want %h", ab, eb);
            else n_pass++;
        end
        wr_exp.delete(); wr_log.delete(); tx_exp.delete(); tx_log.delete();
    endtask

    task automatic test_busy_hold;
        bit ok1, ok2, ok3;
        int tp0, tv0;
        logic [7:0] eb, ab;
        tv0 = txb_viol;
        busy_hold  = 1'b1;
        done_delay = 2;
        load_words(16'h9A78, 16'hDEBC, ok1);
        wait_sig(2, 1'b1, 300, ok2);
        tp0 = tx_pulses;
        repeat (50) @(negedge clk);
        n_checks++;
        if (!ok2 || tx_pulses != tp0)
            $display("FAIL hold_no_start: got read=%0d pulses=%0d want 1 0", ok2, tx_pulses - tp0);
        else n_pass++;
        busy_hold = 1'b0;
        wait_sig(3, 1'b0, 3000, ok3);
        n_checks++;
        if (!(ok1 && ok3)) $display("FAIL hold_complete: got load=%0d idle=%0d want 1 1", ok1, ok3);
        else n_pass++;
        n_checks++;
        if (tx_pulses - tp0 != 2 * WC)
            $display("FAIL hold_pulse_count: got %0d want %0d", tx_pulses - tp0, 2 * WC);
        else n_pass++;
        n_checks++;
        if (txb_viol != tv0) $display("FAIL hold_start_while_busy: got %0d want 0", txb_viol - tv0);
        else n_pass++;
        while (tx_exp.size() > 0 && tx_log.size() > 0) begin
            eb = tx_exp.pop_front();
            ab = tx_log.pop_front();
            n_checks++;
            if (ab !== eb) $display("FAIL hold_tx_byte: got %h want %h", ab, eb);
            else n_pass++;
        end
        wr_exp.delete(); wr_log.delete(); tx_exp.delete(); tx_log.delete();
    endtask

    task automatic test_timeout;
        int n;
        model_en = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        n = 0;
        while (!error && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (error !== 1'b1) $display("FAIL tmo_error: got %b want 1", error);
        else n_pass++;
        n_checks++;
        if (n < TMO || n > TMO + 3) $display("FAIL tmo_latency: got %0d cycles want %0d..%0d", n, TMO, TMO + 3);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({error, mem_en, mem_we, mem_re, tx_start} !== 5'b10000)
            $display("FAIL tmo_sticky_strobes: got %b want 10000", {error, mem_en, mem_we, mem_re, tx_start});
        else n_pass++;
        n_checks++;
        if (wr_log.size() != 0) $display("FAIL tmo_no_write: got %0d want 0", wr_log.size());
        else n_pass++;
        rst = 1'b1;
        model_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({error, busy} !== 2'b00) $display("FAIL tmo_recover: got %b want 00", {error, busy});
        else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        test_reset();
        test_basic();
        test_done_delay();
        test_overrun();
        test_reset_mid_write();
        test_busy_hold();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
